// File: rtl/div_controller_pkg.sv
// Shared types for the iterative divider: FSM state encoding, iteration count
// and the register-value type used by the execute stage.
package div_controller_pkg;

  localparam int DIV_ITERATIONS = 32;

  typedef logic [DIV_ITERATIONS-1:0] regval_t;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_t;

  typedef struct packed {
    logic    is_signed;
    regval_t numer;
    regval_t denom;
  } div_req_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare
// against the divisor magnitude, conditionally subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   prem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // Partial remainder always stays below the divisor, so the MSB shifted out is zero.
  assign shifted = (prem_i << 1) | {{WIDTH{1'b0}}, dvd_bit_i};
  assign dvs_ext = {1'b0, dvs_i};
  assign q_bit_o = (shifted >= dvs_ext);
  assign prem_o  = q_bit_o ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/div_controller.sv
// Sequencer for a shared iterative signed/unsigned divider, one step per clock.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |numer| < |denom|.
module div_controller
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DIV_ITERATIONS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             out_valid,
  input  logic             out_hold,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             has_overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             n_neg, d_neg;
  logic [WIDTH-1:0] n_mag, d_mag;
  logic [WIDTH:0]   step_prem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .q_bit_o   (step_q)
  );

  assign in_ready  = ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && !out_hold)) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DIV_DONE);
  assign busy      = (state_q == DIV_RUN) || (state_q == DIV_FIXUP);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign has_overflow = ovf_q;

  // Unsigned negation of the most-negative value yields itself, which is its exact magnitude.
  assign n_neg = is_signed && numer[WIDTH-1];
  assign d_neg = is_signed && denom[WIDTH-1];
  assign n_mag = n_neg ? (~numer + 1'b1) : numer;
  assign d_mag = d_neg ? (~denom + 1'b1) : denom;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;

    case (state_q)
      DIV_RUN: begin
        dvd_d  = dvd_q << 1;
        prem_d = step_prem;
        quo_d  = {quo_q[WIDTH-2:0], step_q};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = DIV_FIXUP;
        end
      end
      DIV_FIXUP: begin
        quotient_d  = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_r_q ? (~prem_q[WIDTH-1:0] + 1'b1) : prem_q[WIDTH-1:0];
        ovf_d       = 1'b0;
        state_d     = DIV_DONE;
      end
      DIV_DONE: begin
        if (!out_hold) state_d = DIV_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      dvd_d   = n_mag;
      dvs_d   = d_mag;
      prem_d  = '0;
      quo_d   = '0;
      neg_q_d = n_neg ^ d_neg;
      neg_r_d = n_neg;
      cnt_d   = CNT_LOAD;
      state_d = DIV_RUN;
      if (denom == '0) begin
        quotient_d  = '1;
        remainder_d = numer;
        ovf_d       = 1'b1;
        state_d     = DIV_DONE;
      end else if (is_signed && (numer == {1'b1, {(WIDTH-1){1'b0}}}) && (denom == '1)) begin
        quotient_d  = {1'b1, {(WIDTH-1){1'b0}}};
        remainder_d = '0;
        ovf_d       = 1'b1;
        state_d     = DIV_DONE;
      end
`ifdef DIV_EARLY_OUT_EN
      else if (n_mag < d_mag) begin
        quotient_d  = '0;
        remainder_d = numer;
        ovf_d       = 1'b0;
        state_d     = DIV_DONE;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: reset, signed/unsigned results, special
// cases, latency, hold/release back-to-back and reset mid-operation.
module tb_div_controller;
  import div_controller_pkg::*;

  logic    clock = 1'b0;
  logic    reset;
  logic    in_valid, in_ready, is_signed;
  regval_t numer, denom;
  logic    out_valid, out_hold;
  regval_t quotient, remainder;
  logic    has_overflow, busy;

  int npass = 0;
  int ntotal = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 0;
`else
  localparam int SMALL_LAT = 33;
`endif

  div_controller #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .numer(numer), .denom(denom), .out_valid(out_valid),
    .out_hold(out_hold), .quotient(quotient), .remainder(remainder),
    .has_overflow(has_overflow), .busy(busy)
  );

  always #5 clock = ~clock;

  // Present a request and return #1 after the accepting edge.
  task automatic do_req(input logic s, input regval_t n, input regval_t d);
    int k;
    @(negedge clock);
    in_valid = 1'b1; is_signed = s; numer = n; denom = d;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (k >= 100) begin
      ntotal++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid rises.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input regval_t eq, input regval_t er, input logic eo);
    ntotal++;
    if (lat !== exp_lat) $display("FAIL %s_latency got %0d required %0d", name, lat, exp_lat);
    else npass++;
    ntotal++;
    if (quotient !== eq) $display("FAIL %s_quotient got %h required %h", name, quotient, eq);
    else npass++;
    ntotal++;
    if (remainder !== er) $display("FAIL %s_remainder got %h required %h", name, remainder, er);
    else npass++;
    ntotal++;
    if (has_overflow !== eo) $display("FAIL %s_overflow got %b required %b", name, has_overflow, eo);
    else npass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; is_signed = 1'b0; numer = '0; denom = '0; out_hold = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    ntotal++;
    if ({out_valid, busy, has_overflow, in_ready} !== 4'b0000)
      $display("FAIL reset_flags got v=%b b=%b o=%b r=%b required 0000", out_valid, busy, has_overflow, in_ready);
    else npass++;
    ntotal++;
    if ({quotient, remainder} !== 64'd0)
      $display("FAIL reset_data got q=%h r=%h required 0", quotient, remainder);
    else npass++;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b required 1", in_ready);
    else npass++;
  endtask

  task automatic test_unsigned();
    int lat;
    do_req(1'b0, 32'd100, 32'd7);
    ntotal++;
    if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL run_busy got b=%b r=%b required b=1 r=0", busy, in_ready);
    else npass++;
    wait_valid(lat);
    check_result("u100_7", lat, 33, 32'd14, 32'd2, 1'b0);
  endtask

  task automatic test_signed();
    int lat;
    do_req(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_valid(lat);
    check_result("sn100_7", lat, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    do_req(1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_valid(lat);
    check_result("s100_n7", lat, 33, 32'hFFFF_FFF2, 32'd2, 1'b0);
    do_req(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_valid(lat);
    check_result("sn100_n7", lat, 33, 32'd14, 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_special();
    int lat;
    do_req(1'b0, 32'd5, 32'd0);
    wait_valid(lat);
    check_result("div0", lat, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    check_result("sovf", lat, 0, 32'h8000_0000, 32'd0, 1'b1);
    // Same operands unsigned are an ordinary division: 0 r 0x8000_0000.
    do_req(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    check_result("u_big", lat, SMALL_LAT, 32'd0, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_early_out();
    int lat;
    do_req(1'b0, 32'd3, 32'd10);
    wait_valid(lat);
    check_result("u3_10", lat, SMALL_LAT, 32'd0, 32'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    do_req(1'b0, 32'd100, 32'd7);
    @(negedge clock); out_hold = 1'b1;
    wait_valid(lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) bad++;
    end
    ntotal++;
    if (bad != 0) $display("FAIL hold_stable unstable_cycles=%0d required 0", bad);
    else npass++;
    @(negedge clock);
    out_hold = 1'b0; in_valid = 1'b1; is_signed = 1'b0; numer = 32'd9; denom = 32'd3;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL release_ready got %b required 1", in_ready);
    else npass++;
    @(posedge clock); #1;
    in_valid = 1'b0;
    ntotal++;
    if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL release_accept got v=%b b=%b required v=0 b=1", out_valid, busy);
    else npass++;
    wait_valid(lat);
    check_result("u9_3", lat, 33, 32'd3, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    do_req(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    ntotal++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || quotient !== 32'd0)
      $display("FAIL mid_reset got v=%b b=%b q=%h required 0 0 0", out_valid, busy, quotient);
    else npass++;
    @(negedge clock); reset = 1'b0;
    #1;
    ntotal++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_ready got %b required 1", in_ready);
    else npass++;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    ntotal++;
    if (seen != 0) $display("FAIL mid_reset_discard valid_cycles=%0d required 0", seen);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_early_out();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
